// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave endpoint that turns INCR bursts of up to 256
// beats into accesses on a single-port synchronous SRAM. It handles byte
// strobes and answers SLVERR for beats whose word address lies past the end
// of the memory. Only one burst is in flight at a time, and reads and writes
// are never interleaved.
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int MEM_DEPTH  = 1024,
    parameter int MEM_AW     = 10
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,

    // write address channel
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,

    // write data channel
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [SEL_WIDTH-1:0]  s_axi_wstrb,
    input  logic                  s_axi_wlast,

    // write response channel
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,

    // read address channel
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,

    // read data channel
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,

    // SRAM port
    output logic                  mem_en_o,
    output logic [SEL_WIDTH-1:0]  mem_we_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    // Byte address to word address shift amount.
    localparam int BYTE_SH = $clog2(SEL_WIDTH);

    // Memory depth expressed in the width used for the address arithmetic.
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_DATA  = 3'd1,
        S_WR_RESP  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_DATA  = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // State registers (_q) and their next values (_d)
    // ------------------------------------------------------------------
    state_e                 state_q,    state_d;
    logic                   rr_q,       rr_d;       // 1: read wins a tie
    logic [ADDR_WIDTH-1:0]  base_q,     base_d;     // burst start word
    logic [7:0]             len_q,      len_d;
    logic [7:0]             cnt_q,      cnt_d;
    logic                   werr_q,     werr_d;     // sticky write error
    logic                   bvalid_q,   bvalid_d;
    logic [1:0]             bresp_q,    bresp_d;
    logic                   rvalid_q,   rvalid_d;
    logic [1:0]             rresp_q,    rresp_d;
    logic                   rlast_q,    rlast_d;
    logic [DATA_WIDTH-1:0]  rdata_q,    rdata_d;
    logic                   rd_first_q, rd_first_d; // SRAM data is live this cycle

    // ------------------------------------------------------------------
    // Beat address and arbitration helpers
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  cur_word_s;
    logic                   in_range_s;
    logic                   last_beat_s;
    logic                   grant_w_s;
    logic                   grant_r_s;
    logic                   wr_err_s;

    // The start word never exceeds 2^(ADDR_WIDTH-BYTE_SH)-1, so adding an
    // 8-bit beat count cannot wrap the ADDR_WIDTH-wide sum.
    assign cur_word_s  = base_q + {{(ADDR_WIDTH-8){1'b0}}, cnt_q};
    assign in_range_s  = (cur_word_s < DEPTH_W);
    assign last_beat_s = (cnt_q == len_q);

    // A lone request is always granted. On a tie, the round-robin flag picks
    // the channel, so awready and arready are never both high.
    assign grant_w_s = s_axi_awvalid && (!s_axi_arvalid || !rr_q);
    assign grant_r_s = s_axi_arvalid && (!s_axi_awvalid ||  rr_q);

    // ------------------------------------------------------------------
    // Registered channel outputs
    // ------------------------------------------------------------------
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;

    // The SRAM returns data only during the first RD_DATA cycle. That cycle
    // passes it through; the copy captured at the end of that cycle is held
    // while the master stalls. Error beats enter RD_DATA with rdata_q = 0.
    assign s_axi_rdata  = rd_first_q ? mem_rdata_i : rdata_q;

    // Next-state logic, combinational handshakes and the SRAM strobe.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        werr_d      = werr_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rdata_d     = rdata_q;
        rd_first_d  = rd_first_q;
        wr_err_s    = werr_q;

        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = {SEL_WIDTH{1'b0}};
        mem_addr_o    = {MEM_AW{1'b0}};
        mem_wdata_o   = {DATA_WIDTH{1'b0}};

        case (state_q)
            S_IDLE: begin
                s_axi_awready = grant_w_s;
                s_axi_arready = grant_r_s;
                if (grant_w_s) begin
                    state_d = S_WR_DATA;
                    base_d  = s_axi_awaddr >> BYTE_SH;
                    len_d   = s_axi_awlen;
                    cnt_d   = 8'd0;
                    werr_d  = 1'b0;
                    rr_d    = 1'b1;
                end else if (grant_r_s) begin
                    state_d = S_RD_ISSUE;
                    base_d  = s_axi_araddr >> BYTE_SH;
                    len_d   = s_axi_arlen;
                    cnt_d   = 8'd0;
                    rr_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_en_o    = in_range_s;
                    mem_we_o    = in_range_s ? s_axi_wstrb : {SEL_WIDTH{1'b0}};
                    mem_addr_o  = cur_word_s[MEM_AW-1:0];
                    mem_wdata_o = s_axi_wdata;
                    // A beat past the end of memory, or a wlast that does not
                    // match the beat count, taints the whole burst.
                    wr_err_s    = werr_q || !in_range_s || (s_axi_wlast != last_beat_s);
                    werr_d      = wr_err_s;
                    if (last_beat_s) begin
                        state_d  = S_WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = wr_err_s ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        cnt_d    = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = S_WR_DATA;
                end
            end

            S_WR_RESP: begin
                if (s_axi_bready) begin
                    state_d  = S_IDLE;
                    bvalid_d = 1'b0;
                    bresp_d  = RESP_OKAY;
                end else begin
                    state_d  = S_WR_RESP;
                end
            end

            S_RD_ISSUE: begin
                if (in_range_s) begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = cur_word_s[MEM_AW-1:0];
                end else begin
                    mem_en_o   = 1'b0;
                end
                state_d    = S_RD_DATA;
                rvalid_d   = 1'b1;
                rresp_d    = in_range_s ? RESP_OKAY : RESP_SLVERR;
                rlast_d    = last_beat_s;
                rdata_d    = {DATA_WIDTH{1'b0}};
                rd_first_d = in_range_s;
            end

            S_RD_DATA: begin
                if (rd_first_q) begin
                    rdata_d    = mem_rdata_i;
                    rd_first_d = 1'b0;
                end else begin
                    rdata_d    = rdata_q;
                end
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rresp_d  = RESP_OKAY;
                    rlast_d  = 1'b0;
                    if (last_beat_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD_ISSUE;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = S_RD_DATA;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control FSM and registered channel outputs. An asynchronous reset
    // drops any burst in flight without issuing a response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            base_q     <= {ADDR_WIDTH{1'b0}};
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            werr_q     <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            werr_q     <= werr_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rd_first_q <= rd_first_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave with a behavioural synchronous SRAM.
module tb_axi_sram_slave;

    logic        clk;
    logic        rst_n;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] srd;

    logic [31:0] mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;

    axi_sram_slave dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_bresp   (bresp),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (srd)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears one cycle after a read strobe and
    // is garbage in every other cycle, so a DUT that fails to hold its copy
    // is caught.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                srd <= mem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
                srd <= 32'hBAD0_BAD0;
            end
        end else begin
            srd <= 32'hBAD0_BAD0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lone write-address request, accepted in the current cycle.
    task automatic aw_hs(input logic [31:0] a, input logic [7:0] l);
        awvalid = 1'b1; awaddr = a; awlen = l;
        @(negedge clk);
        chk("awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    // Lone read-address request, accepted in the current cycle.
    task automatic ar_hs(input logic [31:0] a, input logic [7:0] l);
        arvalid = 1'b1; araddr = a; arlen = l;
        @(negedge clk);
        chk("arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
    endtask

    // One write beat with the expected SRAM strobe.
    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l,
                         input logic exp_en, input logic [9:0] exp_word);
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
        @(negedge clk);
        chk("wready", {31'd0, wready}, 32'd1);
        chk("wr_mem_en", {31'd0, mem_en}, {31'd0, exp_en});
        if (exp_en) begin
            chk("wr_mem_addr", {22'd0, mem_addr}, {22'd0, exp_word});
            chk("wr_mem_we", {28'd0, mem_we}, {28'd0, s});
            chk("wr_mem_wdata", mem_wdata, d);
        end
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    // Write response in the cycle after the last beat.
    task automatic bchk(input logic [1:0] exp);
        @(negedge clk);
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, {30'd0, exp});
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    // One read beat: RD_ISSUE cycle, stall cycles, then the accept cycle.
    task automatic rbeat(input logic exp_en, input logic [9:0] exp_word, input logic [31:0] exp_d,
                         input logic [1:0] exp_resp, input logic exp_last, input int stalls);
        @(negedge clk);
        chk("rd_mem_en", {31'd0, mem_en}, {31'd0, exp_en});
        chk("rvalid_issue", {31'd0, rvalid}, 32'd0);
        if (exp_en) begin
            chk("rd_mem_addr", {22'd0, mem_addr}, {22'd0, exp_word});
            chk("rd_mem_we", {28'd0, mem_we}, 32'd0);
        end
        tick();
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            chk("rvalid_stall", {31'd0, rvalid}, 32'd1);
            chk("rdata_stall", rdata, exp_d);
            chk("rlast_stall", {31'd0, rlast}, {31'd0, exp_last});
            tick();
        end
        rready = 1'b1;
        @(negedge clk);
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk("rdata", rdata, exp_d);
        chk("rresp", {30'd0, rresp}, {30'd0, exp_resp});
        chk("rlast", {31'd0, rlast}, {31'd0, exp_last});
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 1'b0; awaddr = 32'd0; awlen = 8'd0;
        wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = 32'd0; arlen = 8'd0;
        rready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bresp", {30'd0, bresp}, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        tick();
        rst_n = 1'b1;

        // ---- arbitration from reset: write wins the first tie ----
        awvalid = 1'b1; awaddr = 32'h10; awlen = 8'd0;
        arvalid = 1'b1; araddr = 32'h10; arlen = 8'd0;
        @(negedge clk);
        chk("arb1_awready", {31'd0, awready}, 32'd1);
        chk("arb1_arready", {31'd0, arready}, 32'd0);
        tick();
        awvalid = 1'b0;
        wbeat(32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 10'd4);
        @(negedge clk);
        chk("single_bvalid", {31'd0, bvalid}, 32'd1);
        chk("single_bresp", {30'd0, bresp}, 32'd0);
        chk("busy_arready", {31'd0, arready}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // ---- second tie: read wins ----
        awvalid = 1'b1; awaddr = 32'h10; awlen = 8'd0;
        @(negedge clk);
        chk("arb2_arready", {31'd0, arready}, 32'd1);
        chk("arb2_awready", {31'd0, awready}, 32'd0);
        tick();
        arvalid = 1'b0;
        rbeat(1'b1, 10'd4, 32'hDEAD_BEEF, 2'b00, 1'b1, 0);

        // ---- third tie: write wins again; byte-strobe write ----
        arvalid = 1'b1; araddr = 32'h10; arlen = 8'd0;
        @(negedge clk);
        chk("arb3_awready", {31'd0, awready}, 32'd1);
        chk("arb3_arready", {31'd0, arready}, 32'd0);
        tick();
        awvalid = 1'b0;
        wbeat(32'h1122_3344, 4'h5, 1'b1, 1'b1, 10'd4);
        @(negedge clk);
        chk("strb_bvalid", {31'd0, bvalid}, 32'd1);
        chk("strb_bresp", {30'd0, bresp}, 32'd0);
        chk("busy2_arready", {31'd0, arready}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge clk);
        chk("strb_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        rbeat(1'b1, 10'd4, 32'hDE22_BE44, 2'b00, 1'b1, 0);

        // ---- 4-beat write at 0x20, then a stalled 4-beat read ----
        aw_hs(32'h20, 8'd3);
        wbeat(32'hC0DE_0008, 4'hF, 1'b0, 1'b1, 10'd8);
        wbeat(32'hC0DE_0009, 4'hF, 1'b0, 1'b1, 10'd9);
        wbeat(32'hC0DE_000A, 4'hF, 1'b0, 1'b1, 10'd10);
        wbeat(32'hC0DE_000B, 4'hF, 1'b1, 1'b1, 10'd11);
        bchk(2'b00);
        ar_hs(32'h20, 8'd3);
        rbeat(1'b1, 10'd8,  32'hC0DE_0008, 2'b00, 1'b0, 1);
        rbeat(1'b1, 10'd9,  32'hC0DE_0009, 2'b00, 1'b0, 0);
        rbeat(1'b1, 10'd10, 32'hC0DE_000A, 2'b00, 1'b0, 2);
        rbeat(1'b1, 10'd11, 32'hC0DE_000B, 2'b00, 1'b1, 1);

        // ---- range boundary: byte 0xFF8, 3 beats -> words 1022, 1023, 1024 ----
        aw_hs(32'hFF8, 8'd2);
        wbeat(32'h1111_0001, 4'hF, 1'b0, 1'b1, 10'd1022);
        wbeat(32'h2222_0002, 4'hF, 1'b0, 1'b1, 10'd1023);
        wbeat(32'h3333_0003, 4'hF, 1'b1, 1'b0, 10'd0);
        bchk(2'b10);
        ar_hs(32'hFF8, 8'd2);
        rbeat(1'b1, 10'd1022, 32'h1111_0001, 2'b00, 1'b0, 0);
        rbeat(1'b1, 10'd1023, 32'h2222_0002, 2'b00, 1'b0, 1);
        rbeat(1'b0, 10'd0,    32'h0000_0000, 2'b10, 1'b1, 1);

        // ---- protocol error: early wlast on a 2-beat burst ----
        aw_hs(32'h40, 8'd1);
        wbeat(32'h5555_0000, 4'hF, 1'b1, 1'b1, 10'd16);
        wbeat(32'h5555_0001, 4'hF, 1'b0, 1'b1, 10'd17);
        bchk(2'b10);

        // ---- reset in RD_DATA aborts the read ----
        ar_hs(32'h10, 8'd0);
        tick();
        @(negedge clk);
        chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_rst_rlast", {31'd0, rlast}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        rst_n = 1'b1;
        awvalid = 1'b1; awaddr = 32'h0; awlen = 8'd0;
        arvalid = 1'b1; araddr = 32'h0; arlen = 8'd0;
        @(negedge clk);
        chk("post_rst_awready", {31'd0, awready}, 32'd1);
        chk("post_rst_arready", {31'd0, arready}, 32'd0);
        chk("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
        #1;
        awvalid = 1'b0;
        arvalid = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_wready", {31'd0, wready}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
